// File: rtl/freq_meter.sv
// Frequency / period meter for an asynchronous input against the system clock.
// Frequency mode counts rising edges per gate window; period mode counts clocks between edges.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clkIn,
  input  logic             rstN,
  input  logic             sigIn,
  input  logic             enable,
  input  logic             mode,
  output logic [CNT_W-1:0] result,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_FULL = CNT_W'(GATE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FREQ = 2'd1,
    S_ARM  = 2'd2,
    S_PER  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             w_rise;
  logic [CNT_W-1:0] r_win_cnt;   // gate counter in FREQ, no-edge wait counter in ARM
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_per_cnt;

  assign w_rise = r_sync2 & ~r_sync3;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= sigIn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstN) begin
      r_state    <= S_IDLE;
      r_win_cnt  <= CNT_ZERO;
      r_edge_cnt <= CNT_ZERO;
      r_per_cnt  <= CNT_ZERO;
      result     <= CNT_ZERO;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_win_cnt  <= CNT_ZERO;
          r_edge_cnt <= CNT_ZERO;
          r_per_cnt  <= CNT_ZERO;
          if (enable) begin
            busy    <= 1'b1;
            r_state <= mode ? S_ARM : S_FREQ;
          end
        end

        S_FREQ: begin
          if (!enable) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            r_win_cnt  <= CNT_ZERO;
            r_edge_cnt <= CNT_ZERO;
          end else if (r_win_cnt == GATE_LAST) begin
            // An edge in the final gate cycle belongs to the ending window
            result     <= r_edge_cnt + CNT_W'(w_rise);
            timeout    <= 1'b0;
            valid      <= 1'b1;
            r_win_cnt  <= CNT_ZERO;
            r_edge_cnt <= CNT_ZERO;
          end else begin
            r_win_cnt  <= r_win_cnt + CNT_ONE;
            r_edge_cnt <= r_edge_cnt + CNT_W'(w_rise);
          end
        end

        S_ARM: begin
          if (!enable) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            r_win_cnt <= CNT_ZERO;
          end else if (w_rise) begin
            r_per_cnt <= CNT_ONE;
            r_win_cnt <= CNT_ZERO;
            r_state   <= S_PER;
          end else if (r_win_cnt == GATE_LAST) begin
            result    <= CNT_ZERO;
            timeout   <= 1'b1;
            valid     <= 1'b1;
            r_win_cnt <= CNT_ZERO;
          end else begin
            r_win_cnt <= r_win_cnt + CNT_ONE;
          end
        end

        S_PER: begin
          if (!enable) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            r_per_cnt <= CNT_ZERO;
          end else if (w_rise) begin
            // The terminating edge also opens the next period
            result    <= r_per_cnt;
            timeout   <= 1'b0;
            valid     <= 1'b1;
            r_per_cnt <= CNT_ONE;
          end else if (r_per_cnt == GATE_FULL) begin
            result    <= CNT_ZERO;
            timeout   <= 1'b1;
            valid     <= 1'b1;
            r_per_cnt <= CNT_ZERO;
            r_win_cnt <= CNT_ZERO;
            r_state   <= S_ARM;
          end else begin
            r_per_cnt <= r_per_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
